// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle main control unit for the MIPS datapath. A Moore FSM sequences
//   each instruction through fetch, decode, execute, memory and write-back. It
//   stalls on MemReady in FETCH, MEMRD and MEMWR. An illegal opcode parks the
//   machine in HALT with Fault set until reset.
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   Op[5:0]            opcode field of the instruction register
//   MemReady           memory completed the current access this cycle
//   Zero               ALU zero flag (only affects PCEn in BRANCH)
//   PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
//   RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0],
//   PCSource[1:0]      datapath controls
//   Fault              sticky illegal-opcode flag
//   State[3:0]         current state code (debug)
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Fault,
  output logic [3:0] State
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd15
  } state_e;

  state_e     state_q, state_d;
  logic       pcwrite_q, pcwrite_d;
  logic       pcwritecond_q, pcwritecond_d;
  logic       iord_q, iord_d;
  logic       memread_q, memread_d;
  logic       memwrite_q, memwrite_d;
  logic       regdst_q, regdst_d;
  logic       memtoreg_q, memtoreg_d;
  logic       regwrite_q, regwrite_d;
  logic       alusrca_q, alusrca_d;
  logic [1:0] alusrcb_q, alusrcb_d;
  logic [1:0] aluop_q, aluop_d;
  logic [1:0] pcsource_q, pcsource_d;
  logic       fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // Moore outputs are decoded from the next state and registered, so they are
  // valid for the whole cycle in which that state is current.
  always_comb begin
    pcwrite_d     = 1'b0;
    pcwritecond_d = 1'b0;
    iord_d        = 1'b0;
    memread_d     = 1'b0;
    memwrite_d    = 1'b0;
    regdst_d      = 1'b0;
    memtoreg_d    = 1'b0;
    regwrite_d    = 1'b0;
    alusrca_d     = 1'b0;
    alusrcb_d     = '0;
    aluop_d       = '0;
    pcsource_d    = '0;
    fault_d       = 1'b0;
    unique case (state_d)
      S_FETCH: begin
        memread_d = 1'b1;
        alusrcb_d = 2'b01;
      end
      S_DECODE: alusrcb_d = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca_d = 1'b1;
        alusrcb_d = 2'b10;
      end
      S_MEMRD: begin
        memread_d = 1'b1;
        iord_d    = 1'b1;
      end
      S_MEMWR: begin
        memwrite_d = 1'b1;
        iord_d     = 1'b1;
      end
      S_MEMWB: begin
        regwrite_d = 1'b1;
        memtoreg_d = 1'b1;
      end
      S_EXEC: begin
        alusrca_d = 1'b1;
        aluop_d   = 2'b10;
      end
      S_RWB: begin
        regwrite_d = 1'b1;
        regdst_d   = 1'b1;
      end
      S_ADDIWB: regwrite_d = 1'b1;
      S_BRANCH: begin
        alusrca_d     = 1'b1;
        aluop_d       = 2'b01;
        pcwritecond_d = 1'b1;
        pcsource_d    = 2'b01;
      end
      S_JUMP: begin
        pcwrite_d  = 1'b1;
        pcsource_d = 2'b10;
      end
      S_HALT: fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pcwrite_q     <= 1'b0;
      pcwritecond_q <= 1'b0;
      iord_q        <= 1'b0;
      memread_q     <= 1'b0;
      memwrite_q    <= 1'b0;
      regdst_q      <= 1'b0;
      memtoreg_q    <= 1'b0;
      regwrite_q    <= 1'b0;
      alusrca_q     <= 1'b0;
      alusrcb_q     <= '0;
      aluop_q       <= '0;
      pcsource_q    <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcwrite_q     <= pcwrite_d;
      pcwritecond_q <= pcwritecond_d;
      iord_q        <= iord_d;
      memread_q     <= memread_d;
      memwrite_q    <= memwrite_d;
      regdst_q      <= regdst_d;
      memtoreg_q    <= memtoreg_d;
      regwrite_q    <= regwrite_d;
      alusrca_q     <= alusrca_d;
      alusrcb_q     <= alusrcb_d;
      aluop_q       <= aluop_d;
      pcsource_q    <= pcsource_d;
      fault_q       <= fault_d;
    end
  end

  // IRWrite and the fetch-time PC increment wait for MemReady so the PC
  // advances exactly once per fetch regardless of stall length.
  logic fetch_done;
  assign fetch_done  = (state_q == S_FETCH) && MemReady;

  assign IRWrite     = fetch_done;
  assign PCWrite     = pcwrite_q | fetch_done;
  assign PCWriteCond = pcwritecond_q;
  assign PCEn        = PCWrite | (pcwritecond_q & Zero);
  assign IorD        = iord_q;
  assign MemRead     = memread_q;
  assign MemWrite    = memwrite_q;
  assign RegDst      = regdst_q;
  assign MemtoReg    = memtoreg_q;
  assign RegWrite    = regwrite_q;
  assign ALUSrcA     = alusrca_q;
  assign ALUSrcB     = alusrcb_q;
  assign ALUOp       = aluop_q;
  assign PCSource    = pcsource_q;
  assign Fault       = fault_q;
  assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Instruction-level reference model: each instruction is expanded into the
//   list of state codes it must visit (with fetch/memory wait cycles), and the
//   expected outputs of every cycle come from the per-state output table.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       Zero;
  logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, Fault;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .Fault(Fault),
    .State(State)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {PCWrite,PCWriteCond,PCEn,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,
  //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,Fault,State}
  function automatic logic [31:0] observed();
    return {10'd0, PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
            RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
            Fault, State};
  endfunction

  function automatic logic [31:0] expected(input int st, input logic mr, input logic z);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0;
    logic m2r = 0, rw = 0, srca = 0, flt = 0;
    logic [1:0] srcb = 0, aop = 0, pcs = 0;
    case (st)
      1:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      2:  srcb = 2'b11;
      3, 10: begin srca = 1; srcb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin srca = 1; aop = 2'b10; end
      8:  begin rw = 1; rdst = 1; end
      11: rw = 1;
      9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      12: begin pcw = 1; pcs = 2'b10; end
      15: flt = 1;
      default: ;
    endcase
    return {10'd0, pcw, pcwc, pcw | (pcwc & z), iord, mrd, mwr, irw, rdst, m2r,
            rw, srca, srcb, aop, pcs, flt, 4'(st)};
  endfunction

  typedef struct { int st; logic mr; } cyc_t;
  cyc_t q[$];

  function automatic void push(input int st, input logic mr);
    cyc_t c;
    c.st = st;
    c.mr = mr;
    q.push_back(c);
  endfunction

  // Expand one instruction into its cycle list.
  function automatic void build(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(1, 1'b0);
    push(1, 1'b1);
    push(2, 1'($urandom));
    case (op)
      6'b100011: begin
        push(3, 1'($urandom));
        for (int i = 0; i < mw; i++) push(4, 1'b0);
        push(4, 1'b1);
        push(5, 1'($urandom));
      end
      6'b101011: begin
        push(3, 1'($urandom));
        for (int i = 0; i < mw; i++) push(6, 1'b0);
        push(6, 1'b1);
      end
      6'b000000: begin push(7, 1'($urandom)); push(8, 1'($urandom)); end
      6'b001000: begin push(10, 1'($urandom)); push(11, 1'($urandom)); end
      6'b000100: push(9, 1'($urandom));
      6'b000010: push(12, 1'($urandom));
      default:   for (int i = 0; i < 12; i++) push(15, 1'($urandom));
    endcase
  endfunction

  // Called just after a rising edge; plays the queued cycles.
  task automatic play(input logic [5:0] op, input logic zfix, input logic zval);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      Op = op;
      MemReady = c.mr;
      Zero = zfix ? zval : 1'($urandom);
      #1;
      chk($sformatf("op%b st%0d", op, c.st), observed(), expected(c.st, c.mr, Zero));
      @(posedge clk); #1;
    end
  endtask

  // Leaves the machine in its first FETCH cycle.
  task automatic do_reset();
    reset = 1'b1;
    MemReady = 1'($urandom);
    Zero = 1'($urandom);
    @(posedge clk); #1;
    chk("reset", observed(), '0);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [5:0] op, input int fw, input int mw,
                     input logic zfix, input logic zval);
    build(op, fw, mw);
    play(op, zfix, zval);
    if (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010}) ;
    else do_reset();
  endtask

  logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b001000, 6'b000010, 6'b111111};

  initial begin
    reset = 1'b1; Op = '0; MemReady = 1'b0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // R-type, zero waits
    run(6'b000000, 0, 0, 1'b0, 1'b0);
    // lw with 3 wait cycles in MEMRD
    run(6'b100011, 0, 3, 1'b0, 1'b0);
    // beq taken then not taken
    run(6'b000100, 0, 0, 1'b1, 1'b1);
    run(6'b000100, 0, 0, 1'b1, 1'b0);
    // sw then j
    run(6'b101011, 0, 0, 1'b0, 1'b0);
    run(6'b000010, 0, 0, 1'b0, 1'b0);
    // illegal opcode: halt, then reset
    run(6'b111111, 0, 0, 1'b0, 1'b0);

    // reset during a MEMRD stall
    push(1, 1'b1); push(2, 1'b1); push(3, 1'b1); push(4, 1'b0); push(4, 1'b0);
    play(6'b100011, 1'b0, 1'b0);
    MemReady = 1'b0;
    do_reset();
    MemReady = 1'b0;
    #1;
    chk("fetch after reset", observed(), expected(1, 1'b0, Zero));

    // random instruction stream with random stalls
    for (int n = 0; n < 80; n++) begin
      int k;
      k = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(0, 5));
      run(ops[k], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
